// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/capture pipeline.
//   DATA_W      default operand/result width (must match the external ALU)
//   FUN_W       width of the ALU function code
//   FLAG_W      width of the packed {carry, zero, negative} flag vector
//   alu_fun_e   function codes; 0 and 7 are illegal
//   FLAG_*      bit positions inside the flag vector
//   is_legal_fun()  true for function codes the ALU actually implements
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int FUN_W  = 3;
  localparam int FLAG_W = 3;

  typedef enum logic [FUN_W-1:0] {
    OP_ILL0 = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_NOT  = 3'd3,
    OP_AND  = 3'd4,
    OP_OR   = 3'd5,
    OP_XOR  = 3'd6,
    OP_ILL7 = 3'd7
  } alu_fun_e;

  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  function automatic logic is_legal_fun(input logic [FUN_W-1:0] fun);
    return (fun != OP_ILL0) && (fun != OP_ILL7);
  endfunction

endpackage

// File: rtl/alu_pipe_slot.sv
// One pipeline slot: a valid bit plus a data register.
//   clk, rst_n   clock, synchronous active-low reset (clears valid and data)
//   load_i       capture data_i and mark the slot valid (wins over clr_i)
//   clr_i        mark the slot empty; data is kept so downstream logic sees
//                the last contents instead of toggling on an empty slot
//   data_i       incoming payload
//   valid_o      slot holds a live entry
//   data_o       registered payload
module alu_pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         clr_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (clr_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/alu_issue_pipe.sv
// Issue/capture pipeline wrapped around an external combinational ALU.
//   clk, rst_n                     clock, synchronous active-low reset
//   in_valid/in_ready              upstream handshake; in_opa/in_opb/in_fun op
//   alu_opa/alu_opb/alu_fun        registered issue slot contents to the ALU
//   alu_result/carry/zero/negative ALU response (combinational from alu_*)
//   out_valid/out_ready            downstream handshake
//   out_result/out_flags           captured result and {carry, zero, negative}
//   out_illegal                    op carried function code 0 or 7
//   op_count                       saturating count of ops delivered downstream
// Two slots give full throughput; in_ready depends combinationally on
// out_ready (no skid buffer).
module alu_issue_pipe #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_opa,
  input  logic [DATA_W-1:0] in_opb,
  input  logic [2:0]        in_fun,
  output logic [DATA_W-1:0] alu_opa,
  output logic [DATA_W-1:0] alu_opb,
  output logic [2:0]        alu_fun,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  input  logic              alu_negative,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [2:0]        out_flags,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  op_count
);

  import alu_pkg::*;

  localparam int S1_W = 2*DATA_W + FUN_W;
  localparam int S2_W = DATA_W + FLAG_W + 1;

  logic            s1_valid, s2_valid;
  logic [S1_W-1:0] s1_data;
  logic [S2_W-1:0] s2_din, s2_data;
  logic            s1_load, s2_adv, s2_drain;
  logic [FLAG_W-1:0] alu_flags;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // S2 takes the S1 entry when it is empty or emptying this cycle; S1 can
  // then accept a new op in the same cycle.
  assign s2_drain = s2_valid && out_ready;
  assign s2_adv   = s1_valid && (!s2_valid || out_ready);
  assign in_ready = !s1_valid || s2_adv;
  assign s1_load  = in_valid && in_ready;

  // ---- stage S1: issue slot, drives the ALU ----
  alu_pipe_slot #(.W(S1_W)) u_s1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (s1_load),
    .clr_i   (s2_adv),
    .data_i  ({in_fun, in_opb, in_opa}),
    .valid_o (s1_valid),
    .data_o  (s1_data)
  );

  assign {alu_fun, alu_opb, alu_opa} = s1_data;

  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_C] = alu_carry;
    alu_flags[FLAG_Z] = alu_zero;
    alu_flags[FLAG_N] = alu_negative;
  end

  // Illegal codes still go to the ALU unchanged; the tag is derived here.
  assign s2_din = {!is_legal_fun(alu_fun), alu_flags, alu_result};

  // ---- stage S2: capture slot, drives the output ----
  alu_pipe_slot #(.W(S2_W)) u_s2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (s2_adv),
    .clr_i   (s2_drain),
    .data_i  (s2_din),
    .valid_o (s2_valid),
    .data_o  (s2_data)
  );

  assign {out_illegal, out_flags, out_result} = s2_data;
  assign out_valid = s2_valid;

  always_comb begin
    cnt_d = cnt_q;
    if (s2_drain && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign op_count = cnt_q;

endmodule

// File: tb/tb_alu_issue_pipe.sv
module tb_alu_issue_pipe;

  localparam int DW  = 32;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_opa, in_opb;
  logic [2:0]    in_fun;
  logic [DW-1:0] alu_opa, alu_opb;
  logic [2:0]    alu_fun;
  logic [DW-1:0] alu_result;
  logic          alu_carry, alu_zero, alu_negative;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic [2:0]    out_flags;
  logic          out_illegal;
  logic [CW-1:0] op_count;

  always #5 clk = ~clk;

  alu_issue_pipe #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opa       (in_opa),
    .in_opb       (in_opb),
    .in_fun       (in_fun),
    .alu_opa      (alu_opa),
    .alu_opb      (alu_opb),
    .alu_fun      (alu_fun),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero),
    .alu_negative (alu_negative),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .out_illegal  (out_illegal),
    .op_count     (op_count)
  );

  // Behavioural ALU sitting behind the alu_* ports.
  always_comb begin
    alu_result   = '0;
    alu_carry    = 1'b0;
    alu_negative = 1'b0;
    case (alu_fun)
      3'd1: {alu_carry, alu_result} = {1'b0, alu_opa} + {1'b0, alu_opb};
      3'd2: begin
        alu_result   = alu_opa - alu_opb;
        alu_carry    = alu_opa < alu_opb;
        alu_negative = alu_opa < alu_opb;
      end
      3'd3: alu_result = ~alu_opa;
      3'd4: alu_result = alu_opa & alu_opb;
      3'd5: alu_result = alu_opa | alu_opb;
      3'd6: alu_result = alu_opa ^ alu_opb;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  // Reference: expected {illegal, carry, zero, negative, result} of one op.
  function automatic logic [35:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint unsigned ua = a, ub = b, r = 0;
    logic c = 1'b0, n = 1'b0, ill;
    logic [31:0] res;
    ill = (f == 3'd0) || (f == 3'd7);
    case (f)
      3'd1: begin r = ua + ub; c = (r > 64'hFFFF_FFFF); end
      3'd2: begin c = (ua < ub); n = c; r = ua + 64'h1_0000_0000 - ub; end
      3'd3: r = ua ^ 64'hFFFF_FFFF;
      3'd4: r = ua & ub;
      3'd5: r = ua | ub;
      3'd6: r = ua ^ ub;
      default: r = 0;
    endcase
    r   = r & 64'hFFFF_FFFF;
    res = r[31:0];
    return {ill, c, (r == 0), n, res};
  endfunction

  typedef struct {
    logic [35:0] exp;
    int          t;
  } item_t;

  item_t       q[$];
  int          cyc;
  int          cnt_m;
  logic [31:0] last_a, last_b;
  logic [2:0]  last_f;
  int          checks, failures;
  int          ndel;
  logic        acc, del;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock with the inputs currently driven; updates the model from the
  // handshakes seen before the edge, then checks outputs at the next negedge.
  task automatic cycle();
    bit ev;
    item_t it;
    #1;
    if (rst_n) check("in_ready", in_ready, (q.size() < 2) || out_ready);
    acc = rst_n && in_valid && in_ready;
    del = rst_n && out_valid && out_ready;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      q.delete();
      cnt_m  = 0;
      last_a = '0; last_b = '0; last_f = '0;
    end else begin
      if (del && q.size() > 0) begin
        void'(q.pop_front());
        ndel++;
        if (cnt_m < (1 << CW) - 1) cnt_m++;
      end
      if (acc) begin
        it.exp = ref_op(in_fun, in_opa, in_opb);
        it.t   = cyc;
        q.push_back(it);
        last_a = in_opa; last_b = in_opb; last_f = in_fun;
      end
    end
    @(negedge clk);
    ev = (q.size() > 0) && (cyc - q[0].t >= 1);
    check("out_valid", out_valid, ev);
    if (ev && out_valid) begin
      check("out_result", out_result, q[0].exp[31:0]);
      check("out_flags", out_flags, q[0].exp[34:32]);
      check("out_illegal", out_illegal, q[0].exp[35]);
    end
    check("op_count", op_count, cnt_m);
    check("alu_opa", alu_opa, last_a);
    check("alu_opb", alu_opb, last_b);
    check("alu_fun", alu_fun, last_f);
  endtask

  task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bit done = 0;
    in_valid = 1'b1; in_fun = f; in_opa = a; in_opb = b;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle();
      if (acc) done = 1;
    end
    if (!done) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  logic [2:0]  mix_f[8] = '{3'd4, 3'd5, 3'd6, 3'd3, 3'd4, 3'd5, 3'd6, 3'd3};
  logic [31:0] sa[3], sb[3];

  initial begin
    int idx, d0;
    bit pending;
    checks = 0; failures = 0; cyc = 0; cnt_m = 0; ndel = 0;
    last_a = '0; last_b = '0; last_f = '0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_opa = '0; in_opb = '0; in_fun = '0;
    cycle();
    cycle();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_flags", out_flags, 0);
    check("rst_out_illegal", out_illegal, 0);
    check("rst_op_count", op_count, 0);
    rst_n = 1'b1;

    // add with carry-out and zero result
    send(3'd1, 32'hFFFF_FFFF, 32'h1);
    cycle();
    check("add_valid", out_valid, 1);
    check("add_result", out_result, 32'h0);
    check("add_flags", out_flags, 3'b110);
    check("add_illegal", out_illegal, 0);

    send(3'd2, 32'd3, 32'd5);
    cycle();
    check("sub_neg_result", out_result, 32'hFFFF_FFFE);
    check("sub_neg_flags", out_flags, 3'b101);

    send(3'd2, 32'd5, 32'd5);
    cycle();
    check("sub_eq_result", out_result, 32'h0);
    check("sub_eq_zn", out_flags[1:0], 2'b10);
    cycle();

    // back-to-back logic ops
    do_reset();
    d0 = ndel;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_fun = mix_f[i]; in_opa = $urandom; in_opb = $urandom;
      cycle();
      check("b2b_accept", acc, 1);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check("b2b_delivered", ndel - d0, 8);
    check("b2b_op_count", op_count, 8);

    // stall: three ops offered while downstream is blocked
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin sa[i] = $urandom; sb[i] = $urandom; end
    idx = 0; d0 = ndel;
    for (int i = 0; i < 5; i++) begin
      in_valid = (idx < 3); in_fun = 3'd6; in_opa = sa[idx % 3]; in_opb = sb[idx % 3];
      cycle();
      if (acc) idx++;
    end
    check("stall_accepted", idx, 2);
    check("stall_in_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (idx < 3 || q.size() > 0); i++) begin
      in_valid = (idx < 3); in_fun = 3'd6; in_opa = sa[idx % 3]; in_opb = sb[idx % 3];
      cycle();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("stall_all_accepted", idx, 3);
    check("stall_delivered", ndel - d0, 3);

    // illegal function code
    send(3'd7, 32'h12, 32'h34);
    cycle();
    check("ill_valid", out_valid, 1);
    check("ill_result", out_result, 32'h0);
    check("ill_zero", out_flags[1], 1);
    check("ill_flag", out_illegal, 1);
    cycle();

    // reset with both slots occupied
    out_ready = 1'b0;
    send(3'd1, 32'd1, 32'd2);
    send(3'd4, 32'hF0, 32'hFF);
    check("full_before_rst", out_valid, 1);
    do_reset();
    check("rst_full_out_valid", out_valid, 0);
    check("rst_full_op_count", op_count, 0);
    check("rst_full_in_ready", in_ready, 1);

    // randomized traffic, includes op_count saturation and mid-run resets
    pending = 0;
    for (int i = 0; i < 600; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!pending && $urandom_range(0, 3) != 0) begin
        pending = 1;
        in_fun = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
          0: begin in_opa = 32'hFFFF_FFFF; in_opb = $urandom_range(0, 2); end
          1: begin in_opa = $urandom_range(0, 8); in_opb = $urandom_range(0, 8); end
          default: begin in_opa = $urandom; in_opb = $urandom; end
        endcase
      end
      in_valid = pending;
      rst_n = ($urandom_range(0, 249) != 0);
      cycle();
      if (!rst_n) pending = 0;
      if (acc) pending = 0;
      rst_n = 1'b1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) cycle();
    check("final_drain", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
